data_cache: RTL and testbench
=============================

# data_cache

Direct-mapped, write-back, write-allocate data cache between the pipeline's memory stage and `DataMemory`. It accepts one word request at a time over a valid/ready handshake. Hits are served from internal arrays. Misses write back a dirty victim line and refill over `DataMemory`'s single-word asynchronous-read / synchronous-write port. Hit and miss totals are kept for performance measurement.

## Interface
- `LINE_COUNT`, 16: number of lines. Power of two; index width `IW = log2(LINE_COUNT)`.
- Line size is fixed at 4 words (16 bytes).
- Address split: `[1:0]` byte offset (ignored), `[3:2]` word, `[IW+3:4]` index, `[31:IW+4]` tag.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `req_valid` in 1: CPU request present.
- `req_write` in 1: 1 = store, 0 = load.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data.
- `ready` out 1: cache can accept a request this cycle.
- `resp_valid` out 1: one-cycle pulse; request complete.
- `resp_rdata` out 32: load data, valid with `resp_valid`; 0 for stores.
- `mem_addr` out 32: byte address to `DataMemory`.
- `mem_din` out 32: write data to `DataMemory`.
- `mem_read` out 1: `DataMemory` read enable.
- `mem_write` out 1: `DataMemory` write enable.
- `mem_dout` in 32: `DataMemory` read data, combinational in the same cycle.
- `hit_count` out 32: completed hits; wraps modulo 2^32.
- `miss_count` out 32: misses; wraps modulo 2^32.

## Operation
- **Storage per line:** valid bit, dirty bit, tag, 4 data words. Reset clears every valid and dirty bit; data and tag contents are don't-care.
- **States:** IDLE, LOOKUP, WRITEBACK, REFILL; 2-bit word counter `cnt`.
- **IDLE:** `ready = 1`. On `req_valid`, latch `req_write`, `req_addr` and `req_wdata`, then go to LOOKUP. Later changes on the request inputs are ignored until the next acceptance.
- **LOOKUP, hit** (line valid and tags equal):
  - Load: `resp_rdata` = stored word.
  - Store: write the word, set dirty, `resp_rdata = 0`.
  - `resp_valid = 1`; `hit_count` increments unless this LOOKUP is a post-refill retry; next state IDLE.
- **LOOKUP, miss:** `miss_count` increments. Next state is WRITEBACK if the line is valid and dirty, otherwise REFILL. `cnt = 0`.
- **WRITEBACK:** `mem_write = 1`, `mem_addr = {stored tag, index, cnt, 2'b00}`, `mem_din` = stored word `cnt`. After `cnt == 3`, go to REFILL with `cnt = 0`. Clear dirty on exit.
- **REFILL:** `mem_read = 1`, `mem_addr = {req tag, index, cnt, 2'b00}`. Capture `mem_dout` into word `cnt` at the clock edge. After `cnt == 3`, set valid, write the tag, clear dirty, and return to LOOKUP. That LOOKUP is a guaranteed hit and is not counted as a hit.
- **Store miss:** refill first, then merge the store in the retry LOOKUP (write-allocate). `DataMemory` is not written by a store.
- **Simultaneous events:** `req_valid` while `ready = 0` is ignored; no request is queued.
- **Memory-side outputs:** `mem_read` and `mem_write` are never both 1. Both are 0 in IDLE and LOOKUP. `mem_addr` and `mem_din` are 0 when both enables are 0.

## Timing
- **Reset values:** state IDLE, `ready = 0` while `reset = 1` and 1 afterwards, `resp_valid = 0`, `resp_rdata = 0`, `mem_* = 0`, both counters 0.
- **Reset mid-operation:** aborts immediately and no response is issued. A partial writeback may leave some victim words already written to `DataMemory`; this is acceptable. All lines become invalid.
- **Latency:** accept at edge 0.
  - Hit: `resp_valid` in cycle 1.
  - Clean miss: resp in cycle 6 (LOOKUP, REFILL x4, LOOKUP).
  - Dirty miss: resp in cycle 10 (LOOKUP, WRITEBACK x4, REFILL x4, LOOKUP).
- **Back-to-back:** `ready` returns in the cycle after `resp_valid`, so the next request can be accepted 2 cycles after the previous acceptance on hits.
- **Counter update:** counters update at the edge ending LOOKUP.

## Test plan
- **Cold load miss then hit:** after reset, preload mem byte 0x100 = 0xDEADBEEF and 0x104 = 0x11111111.
  - Load 0x100: resp in cycle 6, rdata 0xDEADBEEF, 4 `mem_read` cycles at 0x100/0x104/0x108/0x10C, `miss_count = 1`.
  - Then load 0x104: resp in cycle 1, rdata 0x11111111, `hit_count = 1`, no memory activity.
- **Store hit:** with the line above resident, store 0x108 = 0x12345678.
  - Resp in cycle 1, `mem_write` never asserted.
  - Load 0x108 returns 0x12345678; `DataMemory` 0x108 is unchanged.
- **Dirty eviction:** then load 0x200 (index 0, different tag).
  - 4 `mem_write` cycles at 0x100..0x10C, then memory 0x108 = 0x12345678.
  - 4 `mem_read` cycles at 0x200..0x20C; resp in cycle 10; `miss_count = 2`.
- **Store miss, clean line:** store 0x314 = 0xCAFEF00D.
  - Refill 0x310..0x31C, resp in cycle 6, `DataMemory` 0x314 unchanged.
  - Load 0x314 hits with 0xCAFEF00D.
- **Reset mid-refill:** assert `reset` during the 2nd REFILL cycle.
  - `mem_read = 0` the following cycle, no `resp_valid`, counters 0.
  - The same load afterwards misses again.
- **Handshake:** hold `req_valid = 1` with changing addresses during a miss.
  - The in-flight request is unaffected and exactly one response is produced per acceptance.

Source files
------------

// File: rtl/data_cache.sv
// -----------------------------------------------------------------------------
// data_cache
//   Direct-mapped, write-back, write-allocate data cache between the pipeline
//   memory stage and DataMemory. One word request is in flight at a time.
//   Lines are 4 words; address split is [3:2] word, [IW+3:4] index,
//   [31:IW+4] tag, byte offset ignored.
//
// Handshake: a request is accepted on a clock edge where req_valid and ready
//   are both 1. ready is 1 only in IDLE and never during reset. The request
//   fields are captured at acceptance; later changes on the request inputs
//   are ignored. Every accepted request yields exactly one resp_valid pulse
//   (unless reset intervenes, which discards it). Nothing is queued.
//
// Ports:
//   clk, reset      clock; synchronous active-high reset
//   req_valid       CPU request present
//   req_write       1 = store, 0 = load
//   req_addr        byte address
//   req_wdata       store data
//   ready           cache can accept a request this cycle
//   resp_valid      one-cycle completion pulse
//   resp_rdata      load data with resp_valid, 0 for stores
//   mem_addr        byte address to DataMemory (0 when idle)
//   mem_din         write data to DataMemory (0 when idle)
//   mem_read        DataMemory read enable
//   mem_write       DataMemory write enable
//   mem_dout        DataMemory read data, combinational
//   hit_count       completed hits, wraps
//   miss_count      misses, wraps
//   dbg_state       current FSM state (IDLE=0, LOOKUP=1, WRITEBACK=2, REFILL=3)
// -----------------------------------------------------------------------------
module data_cache #(
   parameter int LINE_COUNT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        ready,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_din,
   output logic        mem_read,
   output logic        mem_write,
   input  logic [31:0] mem_dout,
   output logic [31:0] hit_count,
   output logic [31:0] miss_count,
   output logic [1:0]  dbg_state
);

   localparam int IW = $clog2(LINE_COUNT);
   localparam int TW = 32 - IW - 4;

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_LOOKUP    = 2'd1,
      S_WRITEBACK = 2'd2,
      S_REFILL    = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   // Set when the LOOKUP being entered follows a refill; that hit is not counted.
   logic        retry_q, retry_d;
   logic [31:0] hit_q, hit_d;
   logic [31:0] miss_q, miss_d;

   logic        req_write_q;
   logic [31:2] req_addr_q;
   logic [31:0] req_wdata_q;

   logic [LINE_COUNT-1:0] valid_q;
   logic [LINE_COUNT-1:0] dirty_q;
   logic [TW-1:0]         tag_q  [LINE_COUNT];
   logic [31:0]           data_q [LINE_COUNT][4];

   logic [IW-1:0] idx;
   logic [1:0]    word;
   logic [TW-1:0] req_tag;
   logic          hit;

   logic          line_we;
   logic [1:0]    line_wword;
   logic [31:0]   line_wdata;

   assign idx     = req_addr_q[IW+3:4];
   assign word    = req_addr_q[3:2];
   assign req_tag = req_addr_q[31:IW+4];
   assign hit     = valid_q[idx] && (tag_q[idx] == req_tag);

   assign hit_count  = hit_q;
   assign miss_count = miss_q;
   assign dbg_state  = state_q;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      retry_d    = retry_q;
      hit_d      = hit_q;
      miss_d     = miss_q;
      ready      = 1'b0;
      resp_valid = 1'b0;
      resp_rdata = 32'd0;
      mem_addr   = 32'd0;
      mem_din    = 32'd0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      line_we    = 1'b0;
      line_wword = word;
      line_wdata = req_wdata_q;

      unique case (state_q)
         S_IDLE: begin
            ready = 1'b1;
            if (req_valid) state_d = S_LOOKUP;
         end
         S_LOOKUP: begin
            retry_d = 1'b0;
            if (hit) begin
               resp_valid = 1'b1;
               if (req_write_q) line_we = 1'b1;
               else             resp_rdata = data_q[idx][word];
               if (!retry_q) hit_d = hit_q + 32'd1;
               state_d = S_IDLE;
            end else begin
               miss_d  = miss_q + 32'd1;
               cnt_d   = 2'd0;
               state_d = (valid_q[idx] && dirty_q[idx]) ? S_WRITEBACK : S_REFILL;
            end
         end
         S_WRITEBACK: begin
            mem_write = 1'b1;
            mem_addr  = {tag_q[idx], idx, cnt_q, 2'b00};
            mem_din   = data_q[idx][cnt_q];
            cnt_d     = cnt_q + 2'd1;   // wraps to 0 for the refill
            if (cnt_q == 2'd3) state_d = S_REFILL;
         end
         S_REFILL: begin
            mem_read   = 1'b1;
            mem_addr   = {req_tag, idx, cnt_q, 2'b00};
            line_we    = 1'b1;
            line_wword = cnt_q;
            line_wdata = mem_dout;
            cnt_d      = cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
               state_d = S_LOOKUP;
               retry_d = 1'b1;
            end
         end
      endcase

      // Reset aborts at once: no handshake and no memory traffic while held.
      if (reset) begin
         ready      = 1'b0;
         resp_valid = 1'b0;
         resp_rdata = 32'd0;
         mem_addr   = 32'd0;
         mem_din    = 32'd0;
         mem_read   = 1'b0;
         mem_write  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= 2'd0;
         retry_q <= 1'b0;
         hit_q   <= 32'd0;
         miss_q  <= 32'd0;
         valid_q <= '0;
         dirty_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         retry_q <= retry_d;
         hit_q   <= hit_d;
         miss_q  <= miss_d;
         if (state_q == S_LOOKUP && hit && req_write_q) dirty_q[idx] <= 1'b1;
         if (state_q == S_WRITEBACK && cnt_q == 2'd3)   dirty_q[idx] <= 1'b0;
         if (state_q == S_REFILL && cnt_q == 2'd3) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
         end
      end
   end

   // Request capture, tags and line data need no reset: valid bits gate them.
   always_ff @(posedge clk) begin
      if (state_q == S_IDLE && req_valid) begin
         req_write_q <= req_write;
         req_addr_q  <= req_addr[31:2];
         req_wdata_q <= req_wdata;
      end
      if (line_we) data_q[idx][line_wword] <= line_wdata;
      if (state_q == S_REFILL && cnt_q == 2'd3) tag_q[idx] <= req_tag;
   end

endmodule

// File: tb/tb_data_cache.sv
// -----------------------------------------------------------------------------
// tb_data_cache
//   Bench for data_cache. A DataMemory model (async read, sync write) is
//   attached to the memory port. Expected responses come from a reference
//   model of the cache's architectural behaviour: a flat memory image of what
//   loads must return, plus which tag each index holds and whether it is dirty.
// -----------------------------------------------------------------------------
module tb_data_cache;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_write;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        ready;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic [31:0] mem_addr;
   logic [31:0] mem_din;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_dout;
   logic [31:0] hit_count;
   logic [31:0] miss_count;
   logic [1:0]  dbg_state;

   data_cache #(.LINE_COUNT(16)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_write  (req_write),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .ready      (ready),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .mem_addr   (mem_addr),
      .mem_din    (mem_din),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .mem_dout   (mem_dout),
      .hit_count  (hit_count),
      .miss_count (miss_count),
      .dbg_state  (dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- DataMemory model (4 KB) ----------------
   logic [31:0] dmem [1024];
   logic        dmem_init = 1'b1;
   assign mem_dout = dmem[mem_addr[11:2]];

   always @(posedge clk) begin
      if (dmem_init) begin
         for (int i = 0; i < 1024; i++) dmem[i] <= $urandom;
         dmem[10'h040] <= 32'hDEADBEEF;   // byte 0x100
         dmem[10'h041] <= 32'h11111111;   // byte 0x104
         dmem_init <= 1'b0;
      end else if (mem_write) begin
         dmem[mem_addr[11:2]] <= mem_din;
      end
   end

   // ---------------- scoreboard ----------------
   typedef struct {
      logic [31:0]      rdata;
      int               lat;
      logic [31:0]      hits;
      logic [31:0]      misses;
      logic             refill;
      logic [31:0]      rd_base;
      logic             wb;
      logic [31:0]      wb_base;
      logic [3:0][31:0] wb_data;
   } exp_t;

   exp_t        exp_q[$];
   int          acc_q[$];
   logic [31:0] rd_obs[$];
   logic [31:0] wa_obs[$];
   logic [31:0] wd_obs[$];

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- reference model ----------------
   logic [31:0] arch_mem [1024];
   logic        m_valid [16];
   logic        m_dirty [16];
   logic [23:0] m_tag   [16];
   logic [31:0] m_hits;
   logic [31:0] m_misses;

   task automatic model_reset();
      for (int i = 0; i < 1024; i++) arch_mem[i] = dmem[i];
      for (int i = 0; i < 16; i++) begin
         m_valid[i] = 1'b0;
         m_dirty[i] = 1'b0;
         m_tag[i]   = 24'd0;
      end
      m_hits   = 32'd0;
      m_misses = 32'd0;
   endtask

   task automatic model_accept(input logic wr, input logic [31:0] addr, input logic [31:0] wd);
      exp_t       e;
      logic [3:0] idx;
      logic [23:0] tag;
      logic [9:0] w;
      idx = addr[7:4];
      tag = addr[31:8];
      w   = addr[11:2];
      e   = '{default: '0};
      if (m_valid[idx] && m_tag[idx] == tag) begin
         m_hits = m_hits + 32'd1;
         e.lat  = 1;
      end else begin
         m_misses  = m_misses + 32'd1;
         e.refill  = 1'b1;
         e.rd_base = {addr[31:4], 4'b0000};
         if (m_valid[idx] && m_dirty[idx]) begin
            e.wb      = 1'b1;
            e.lat     = 10;
            e.wb_base = {m_tag[idx], idx, 4'b0000};
            for (int k = 0; k < 4; k++) e.wb_data[k] = arch_mem[e.wb_base[11:2] + 10'(k)];
         end else begin
            e.lat = 6;
         end
         m_valid[idx] = 1'b1;
         m_tag[idx]   = tag;
         m_dirty[idx] = 1'b0;
      end
      if (wr) begin
         arch_mem[w]  = wd;
         m_dirty[idx] = 1'b1;
         e.rdata      = 32'd0;
      end else begin
         e.rdata = arch_mem[w];
      end
      e.hits   = m_hits;
      e.misses = m_misses;
      exp_q.push_back(e);
   endtask

   // ---------------- monitor ----------------
   logic        cnt_chk = 1'b0;
   logic [31:0] chk_hits, chk_misses;

   always @(negedge clk) begin : monitor
      exp_t e;
      int   a;
      if (reset) begin
         acc_q.delete();
         rd_obs.delete();
         wa_obs.delete();
         wd_obs.delete();
         cnt_chk <= 1'b0;
      end else begin
         if (cnt_chk) begin
            check("hit_count", hit_count, chk_hits);
            check("miss_count", miss_count, chk_misses);
            check("ready_after_resp", {31'd0, ready}, 32'd1);
            cnt_chk <= 1'b0;
         end
         check("mem_enables_exclusive", {31'd0, mem_read & mem_write}, 32'd0);
         if (!mem_read && !mem_write) check("mem_idle_addr_din", mem_addr | mem_din, 32'd0);
         if (mem_read) rd_obs.push_back(mem_addr);
         if (mem_write) begin
            wa_obs.push_back(mem_addr);
            wd_obs.push_back(mem_din);
         end
         if (resp_valid) begin
            if (exp_q.size() == 0 || acc_q.size() == 0) begin
               check("unexpected_resp", {31'd0, resp_valid}, 32'd0);
            end else begin
               e = exp_q.pop_front();
               a = acc_q.pop_front();
               check("latency", 32'(cyc - a), 32'(e.lat));
               check("resp_rdata", resp_rdata, e.rdata);
               check("read_cycles", 32'(rd_obs.size()), e.refill ? 32'd4 : 32'd0);
               for (int i = 0; i < rd_obs.size() && i < 4; i++)
                  check("read_addr", rd_obs[i], e.rd_base + 32'(4 * i));
               check("write_cycles", 32'(wa_obs.size()), e.wb ? 32'd4 : 32'd0);
               for (int i = 0; i < wa_obs.size() && i < 4; i++) begin
                  check("wb_addr", wa_obs[i], e.wb_base + 32'(4 * i));
                  check("wb_data", wd_obs[i], e.wb_data[i]);
               end
               chk_hits   <= e.hits;
               chk_misses <= e.misses;
               cnt_chk    <= 1'b1;
            end
            rd_obs.delete();
            wa_obs.delete();
            wd_obs.delete();
         end
         if (ready && req_valid) acc_q.push_back(cyc);
      end
   end

   // ---------------- driver tasks ----------------
   // Called and returns 1 ns after a rising edge.
   task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                        input int junk);
      int waited;
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = addr;
      req_wdata = wd;
      waited    = 0;
      @(negedge clk);
      while (!ready && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      if (!ready) begin
         check("accept_timeout", {31'd0, ready}, 32'd1);
         req_valid = 1'b0;
         @(posedge clk); #1;
         return;
      end
      model_accept(wr, addr, wd);
      @(posedge clk); #1;
      // Keep presenting changing requests while the cache is busy.
      for (int j = 0; j < junk; j++) begin
         req_addr  = $urandom;
         req_write = 1'($urandom_range(0, 1));
         req_wdata = $urandom;
         @(posedge clk); #1;
      end
      req_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         check("drain_timeout", 32'(exp_q.size()), 32'd0);
         exp_q.delete();
      end
      @(negedge clk);
      @(posedge clk); #1;
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   logic [31:0] orig;

   initial begin
      reset     = 1'b1;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_addr  = 32'd0;
      req_wdata = 32'd0;

      @(negedge clk);
      check("reset_ready", {31'd0, ready}, 32'd0);
      check("reset_resp_valid", {31'd0, resp_valid}, 32'd0);
      check("reset_mem_en", {30'd0, mem_read, mem_write}, 32'd0);
      check("reset_mem_addr", mem_addr, 32'd0);
      @(negedge clk);
      check("reset_hit_count", hit_count, 32'd0);
      check("reset_miss_count", miss_count, 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      model_reset();
      @(negedge clk);
      check("ready_after_reset", {31'd0, ready}, 32'd1);
      @(posedge clk); #1;

      // Cold miss then hit on the same line.
      issue(1'b0, 32'h100, 32'd0, 0); drain();
      issue(1'b0, 32'h104, 32'd0, 0); drain();

      // Store hit, then read back back-to-back; memory stays untouched.
      orig = dmem[10'h042];
      issue(1'b1, 32'h108, 32'h12345678, 0);
      issue(1'b0, 32'h108, 32'd0, 0);
      drain();
      check("dmem_108_after_store_hit", dmem[10'h042], orig);

      // Dirty eviction of index 0.
      issue(1'b0, 32'h200, 32'd0, 0); drain();
      check("dmem_108_after_writeback", dmem[10'h042], 32'h12345678);

      // Store miss into a clean line (write-allocate).
      orig = dmem[10'h0C5];
      issue(1'b1, 32'h314, 32'hCAFEF00D, 0);
      issue(1'b0, 32'h314, 32'd0, 0);
      drain();
      check("dmem_314_after_store_miss", dmem[10'h0C5], orig);

      // Reset during the second refill cycle.
      issue(1'b0, 32'h540, 32'd0, 0);   // now in cycle 1 (lookup)
      @(posedge clk); #1;               // cycle 2
      @(posedge clk); #1;               // cycle 3
      check("refill_active_before_reset", {31'd0, mem_read}, 32'd1);
      reset = 1'b1;
      exp_q.delete();
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check("post_reset_mem_read", {31'd0, mem_read}, 32'd0);
      check("post_reset_resp_valid", {31'd0, resp_valid}, 32'd0);
      check("post_reset_hit_count", hit_count, 32'd0);
      check("post_reset_miss_count", miss_count, 32'd0);
      check("post_reset_ready", {31'd0, ready}, 32'd1);
      model_reset();
      @(posedge clk); #1;
      issue(1'b0, 32'h540, 32'd0, 0); drain();

      // Request inputs keep changing while a miss is in flight.
      issue(1'b0, 32'hA40, 32'd0, 4); drain();
      issue(1'b0, 32'hA48, 32'd0, 0); drain();

      // Randomised traffic, biased towards a few tags for hits and evictions.
      for (int t = 0; t < 400; t++) begin
         logic [3:0]  tg;
         logic [31:0] a;
         int          gap;
         tg  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 2));
         a   = {20'd0, tg, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                2'($urandom_range(0, 3))};
         issue(1'($urandom_range(0, 1)), a, $urandom, 0);
         gap = $urandom_range(0, 2);
         for (int g = 0; g < gap; g++) begin
            @(posedge clk); #1;
         end
      end
      drain();
      check("unmatched_accepts", 32'(acc_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
